xsafe_tx: RTL and testbench
===========================

// Module: xsafe_tx
// PURPOSE
//   Transmit side of the xcheck-monitored data bus. Buffers payload words from an
//   upstream producer and drives them onto a valid/ready output bus. Every output
//   bit is reset and driven from reset registers, so $isunknown(out_data) never fires.
//   Sits directly upstream of xcheck in block-level benches and in the datapath.
// PARAMETERS
//   WIDTH       8     payload width in bits
//   DEPTH       4     buffer entries; power of two, >= 2
//   IDLE_VALUE  '0    value driven on out_data while out_valid = 0
// PORTS
//   clk          in   1          rising-edge clock
//   rst_n        in   1          asynchronous active-low reset
//   in_valid     in   1          upstream word available
//   in_data      in   WIDTH      upstream payload
//   in_ready     out  1          buffer can accept a word this cycle
//   out_valid    out  1          out_data holds a buffered word
//   out_data     out  WIDTH      payload; IDLE_VALUE when out_valid = 0
//   out_parity   out  1          even parity (^out_data); 0 when idle
//   out_ready    in   1          downstream accepts the word
//   sent_count   out  16         count of completed output transfers
//   drop_err     out  1          sticky: in_valid was high while in_ready was low
// BEHAVIOUR
//   Reset (rst_n low, asynchronous assert; removal is synchronous to clk):
//     - count = 0, rd_ptr = wr_ptr = 0, all storage entries = IDLE_VALUE
//     - in_ready = 0 while in reset; 1 on the first clk after release
//     - out_valid = 0, out_data = IDLE_VALUE, out_parity = 0
//     - sent_count = 0, drop_err = 0
//   Buffer:
//     - circular, DEPTH entries; pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0
//     - count is log2(DEPTH)+1 bits
//   Handshakes:
//     - push = in_valid & in_ready; pop = out_valid & out_ready
//     - in_ready = (count != DEPTH), from registered state; no combinational path from out_ready
//     - out_valid = (count != 0)
//     - out_data = storage[rd_ptr] when out_valid, else IDLE_VALUE
//     - out_data and out_parity are stable while out_valid & ~out_ready
//   Latency: a word pushed at edge N is visible on out_data after edge N when the buffer was empty.
//     There is no same-cycle bypass.
//   Simultaneous push and pop:
//     - count is unchanged and both pointers advance
//     - when full, in_ready = 0, so a push cannot occur that cycle
//   Full / empty:
//     - at full, in_ready = 0 and data presented upstream is ignored
//     - at empty, out_ready is ignored and sent_count does not change
//   A popped entry is not cleared. Storage stays at known values because it is only
//     written with in_data on a push.
//   Upstream X is out of scope. in_data is sampled only on a push.
//   sent_count: +1 per pop, wraps 16'hFFFF -> 0.
//   drop_err: set on any cycle with in_valid & ~in_ready after reset release; cleared only by reset.
//   Reset mid-transfer: all buffered words are discarded and outputs return to the reset values
//     immediately, without waiting for clk.
// TESTING
//   1. Reset, then idle with in_valid = 0 for 5 cycles
//      -> out_valid = 0, out_data = 8'h00, out_parity = 0, no $isunknown on outputs.
//   2. Push 8'hA5 with out_ready = 1
//      -> next cycle out_valid = 1, out_data = 8'hA5, out_parity = 0; then idle; sent_count = 1.
//   3. out_ready = 0; push 8'h01, 8'h02, 8'h03, 8'h04
//      -> in_ready drops after the 4th push.
//      Then push 8'h05 -> drop_err = 1.
//      Then release out_ready -> outputs in order 01, 02, 03, 04, out_parity = 1, 1, 0, 1.
//   4. Continuous push and pop of 8'h10..8'h17 with out_ready held high
//      -> pointer wrap is exercised, order is preserved, count stays at 1, sent_count = 8.
//   5. Fill with 8'hFF x3, then assert rst_n = 0 between clk edges
//      -> out_valid = 0 and out_data = 8'h00 before the next edge; sent_count = 0.
//   6. Preload sent_count to 16'hFFFF via 65535 transfers, then pop once more -> sent_count = 16'h0000.

Source files
------------

// File: rtl/xsafe_tx.sv
// Transmit buffer for the xcheck-monitored bus: circular FIFO with valid/ready on both sides.
// Every output is derived from async-reset registers, so no output is ever unknown.
module xsafe_tx #(
    parameter int                   WIDTH      = 8,
    parameter int                   DEPTH      = 4,
    parameter logic [WIDTH-1:0]     IDLE_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_parity,
    input  logic                    out_ready,
    output logic [15:0]             sent_count,
    output logic                    drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = in_valid & ready_q;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // in_ready is registered from the next count, so it is 0 throughout reset
    // and only rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= IDLE_VALUE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ready_q    <= 1'b0;
            sent_count <= 16'h0000;
            drop_err   <= 1'b0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= in_data;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                sent_count <= sent_count + 16'd1;
            end
            if (in_valid && !ready_q) drop_err <= 1'b1;
            count   <= count_next;
            ready_q <= (count_next != FULL);
        end
    end

    assign in_ready   = ready_q;
    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? storage[rd_ptr] : IDLE_VALUE;
    assign out_parity = out_valid ? ^storage[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_xsafe_tx.sv
// Scoreboard bench for xsafe_tx: the driver queues accepted words, and a negedge monitor
// checks every visible output against the queue and the counter/flag model.
module tb_xsafe_tx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_parity;
    logic        out_ready;
    logic [15:0] sent_count;
    logic        drop_err;

    int tests = 0;
    int fails = 0;

    logic [7:0]  q[$];
    logic [15:0] exp_sent = 16'h0000;
    logic        exp_drop = 1'b0;
    logic        armed = 1'b0;
    logic        hold = 1'b0;
    logic [8:0]  hold_val = '0;

    xsafe_tx #(.WIDTH(8), .DEPTH(DEPTH), .IDLE_VALUE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_parity(out_parity),
        .out_ready(out_ready), .sent_count(sent_count), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; entered and left just after a rising edge.
    task automatic step(input logic iv, input logic [7:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        #1;
        if (rst_n && iv && in_ready) q.push_back(id);
        if (rst_n && iv && !in_ready) exp_drop = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", out_valid, 1'b0);
    endtask

    // Monitor: compares outputs with the model and retires words on each transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("no_x", 32'($isunknown({in_ready, out_valid, out_data, out_parity, sent_count, drop_err})), 0);
            chk("in_ready", in_ready, armed && (q.size() != DEPTH));
            chk("out_valid", out_valid, q.size() != 0);
            chk("sent_count", sent_count, exp_sent);
            chk("drop_err", drop_err, exp_drop);
            if (hold) chk("stable", {out_parity, out_data}, hold_val);
            if (q.size() == 0) begin
                chk("idle_data", out_data, 8'h00);
                chk("idle_parity", out_parity, 1'b0);
            end else begin
                chk("out_data", out_data, q[0]);
                chk("out_parity", out_parity, ^q[0]);
                if (out_ready) begin
                    void'(q.pop_front());
                    exp_sent = exp_sent + 16'd1;
                end
            end
            hold     = out_valid && !out_ready;
            hold_val = {out_parity, out_data};
            armed    = 1'b1;
        end else begin
            q.delete();
            exp_sent = 16'h0000;
            exp_drop = 1'b0;
            armed    = 1'b0;
            hold     = 1'b0;
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_parity", out_parity, 1'b0);
        chk("rst_sent", sent_count, 16'h0000);
        chk("rst_drop", drop_err, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready_low", in_ready, 1'b0);

        // Idle five cycles
        repeat (5) step(1'b0, 8'h00, 1'b0);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_out_valid", out_valid, 1'b0);

        // Single word with out_ready high
        step(1'b1, 8'hA5, 1'b1);
        chk("a5_valid", out_valid, 1'b1);
        chk("a5_data", out_data, 8'hA5);
        chk("a5_parity", out_parity, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("a5_sent", sent_count, 16'd1);
        chk("a5_idle", out_valid, 1'b0);

        // Fill with downstream stalled, overflow attempt, then drain in order
        for (int i = 1; i <= 4; i++) begin
            chk("fill_ready", in_ready, 1'b1);
            step(1'b1, 8'(i), 1'b0);
        end
        chk("full_in_ready", in_ready, 1'b0);
        step(1'b1, 8'h05, 1'b0);
        chk("drop_set", drop_err, 1'b1);
        chk("full_head", out_data, 8'h01);
        drain();
        chk("fill_sent", sent_count, 16'd5);

        // Continuous stream across pointer wrap
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b1);
            chk("stream_ready", in_ready, 1'b1);
            chk("stream_data", out_data, 8'h10 + 8'(i));
        end
        drain();
        chk("stream_sent", sent_count, 16'd13);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        drain();

        // Asynchronous reset between edges with words buffered
        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b0);
        chk("ff_valid", out_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_out_data", out_data, 8'h00);
        chk("async_parity", out_parity, 1'b0);
        chk("async_sent", sent_count, 16'h0000);
        chk("async_in_ready", in_ready, 1'b0);
        chk("async_drop", drop_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_ready", in_ready, 1'b1);
        chk("post_rst_valid", out_valid, 1'b0);

        // sent_count wrap: 65535 transfers, then one more
        for (int i = 0; i < 65535; i++) step(1'b1, 8'($urandom), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("sent_ffff", sent_count, 16'hFFFF);
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("sent_wrap", sent_count, 16'h0000);
        chk("wrap_idle", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
